// File: rtl/mem_access_ctrl_if.sv
// Memory bus between the load/store controller (master) and the memory port (slave).
// Request side is registered by the master; ack/rdata are returned by the slave.
interface mem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store unit: aligns and issues one bus access, stalls the pipeline until ack or timeout.
// Load result 1 cycle after ack (min 3 cycles); the bus is held until ack, aborting after TIMEOUT cycles.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_re_in,
  input  logic                     mem_we_in,
  input  logic [31:0]              addr_in,
  input  logic [31:0]              wdata_in,
  input  logic [1:0]               size_in,
  input  logic                     unsigned_in,
  mem_access_ctrl_if.master        bus,
  output logic                     stall,
  output logic [31:0]              rdata_out,
  output logic                     rdata_valid,
  output logic                     misalign_err,
  output logic                     timeout_err
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, next_state;
  logic [7:0]  wait_cnt;
  logic        request, aligned;
  logic        accept, reject, finish_ok, finish_to;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  // Attributes of the in-flight access, needed to extract the load lane on ack.
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic        lat_load;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  assign request = mem_re_in | mem_we_in;

  always_comb begin
    aligned    = 1'b0;
    be_calc    = 4'h0;
    wdata_calc = wdata_in;
    case (size_in)
      2'b00: begin
        aligned    = 1'b1;
        be_calc    = 4'b0001 << addr_in[1:0];
        wdata_calc = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        aligned    = ~addr_in[0];
        be_calc    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata_in[15:0]}};
      end
      2'b10: begin
        aligned    = (addr_in[1:0] == 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = wdata_in;
      end
      default: aligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          if (aligned) begin
            accept     = 1'b1;
            stall      = 1'b1;
            next_state = BUSY;
          end else begin
            reject     = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        // An ack in the last permitted cycle still completes normally.
        if (bus.bus_ack) begin
          finish_ok  = 1'b1;
          next_state = DONE;
        end else if (wait_cnt == LAST_WAIT) begin
          finish_to  = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  always_comb begin
    lane_b = bus.bus_rdata[{lat_off, 3'b000} +: 8];
    lane_h = bus.bus_rdata[{lat_off[1], 4'b0000} +: 16];
    case (lat_size)
      2'b00:   load_ext = lat_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = lat_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0;
      bus.bus_wdata <= 32'h0;
      bus.bus_be    <= 4'h0;
      wait_cnt      <= 8'h0;
      lat_off       <= 2'b00;
      lat_size      <= 2'b00;
      lat_uns       <= 1'b0;
      lat_load      <= 1'b0;
      rdata_out     <= 32'h0;
      rdata_valid   <= 1'b0;
      misalign_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      misalign_err <= reject;
      timeout_err  <= finish_to;
      rdata_valid  <= finish_ok & lat_load;
      if (accept) begin
        // A simultaneous load request is dropped in favour of the store.
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= mem_we_in;
        bus.bus_addr  <= {addr_in[31:2], 2'b00};
        bus.bus_wdata <= wdata_calc;
        bus.bus_be    <= be_calc;
        wait_cnt      <= 8'h0;
        lat_off       <= addr_in[1:0];
        lat_size      <= size_in;
        lat_uns       <= unsigned_in;
        lat_load      <= ~mem_we_in;
      end else if (finish_ok | finish_to) begin
        bus.bus_req <= 1'b0;
        bus.bus_we  <= 1'b0;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (finish_ok & lat_load) rdata_out <= load_ext;
    end
  end

endmodule
